// File: rtl/priority_encoder8_3.sv
// priority_encoder8_3
// Registered 8-to-3 priority encoder. Request lines are captured into a
// pending register. A two-state FSM grants the highest-priority pending bit
// and holds that grant until the consumer acknowledges it. On an accepted
// ack the granted bit is cleared, unless the same bit is re-requested in
// that cycle.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
module priority_encoder8_3 #(
    parameter bit PRIORITY_HIGH = 1'b1   // 1: bit 7 wins, 0: bit 0 wins
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] in,
    input  logic       ack,
    output logic [2:0] out,
    output logic       valid,
    output logic [7:0] pending
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_pending;
    logic [7:0] w_pending_next;
    logic [2:0] r_out;
    logic [2:0] w_out_next;
    logic       r_valid;
    logic       w_valid_next;
    logic [7:0] w_clr;
    logic [2:0] w_sel_idx;
    logic       w_accept;

    // Accepted ack: only meaningful while a grant is being held
    assign w_accept = (r_state == HOLD) && ack;

    // One-hot clear mask of the granted index; set-wins is applied below by
    // OR-ing the new requests in after the clear
    assign w_clr          = w_accept ? (8'(1) << r_out) : 8'h00;
    assign w_pending_next = (r_pending & ~w_clr) | (en ? in : 8'h00);

    // Highest-priority set bit of the registered pending vector; the last
    // assignment in the scan order wins, so scan toward the winning end
    always_comb begin
        w_sel_idx = 3'd0;
        if (PRIORITY_HIGH) begin
            for (int i = 0; i < 8; i++) begin
                if (r_pending[i]) w_sel_idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (r_pending[i]) w_sel_idx = 3'(i);
            end
        end
    end

    // Next-state and next-output logic of the grant FSM
    always_comb begin
        w_state_next = r_state;
        w_out_next   = r_out;
        w_valid_next = r_valid;
        case (r_state)
            IDLE: begin
                if (r_pending != 8'h00) begin
                    w_out_next   = w_sel_idx;
                    w_valid_next = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (ack) begin
                    w_valid_next = 1'b0;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_valid_next = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    // State, grant and pending registers; reset discards everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= 8'h00;
            r_out     <= 3'd0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
            r_out     <= w_out_next;
            r_valid   <= w_valid_next;
        end
    end

    assign out     = r_out;
    assign valid   = r_valid;
    assign pending = r_pending;

endmodule

// File: tb/tb_priority_encoder8_3.sv
// Directed bench for priority_encoder8_3. Two instances share all inputs:
// one is built with bit 7 highest (hi) and one with bit 0 highest (lo).
module tb_priority_encoder8_3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] in;
    logic       ack;
    logic [2:0] hi_out;
    logic       hi_valid;
    logic [7:0] hi_pending;
    logic [2:0] lo_out;
    logic       lo_valid;
    logic [7:0] lo_pending;

    int vectors;
    int miscompares;

    priority_encoder8_3 #(.PRIORITY_HIGH(1'b1)) u_hi (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in      (in),
        .ack     (ack),
        .out     (hi_out),
        .valid   (hi_valid),
        .pending (hi_pending)
    );

    priority_encoder8_3 #(.PRIORITY_HIGH(1'b0)) u_lo (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in      (in),
        .ack     (ack),
        .out     (lo_out),
        .valid   (lo_valid),
        .pending (lo_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
            $display("check %-22s observed=%h expected=%h", tag, obs, exp);
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle a little after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset with all requests driven: nothing may be captured
        rst_n = 1'b0; en = 1'b1; in = 8'hFF; ack = 1'b0;
        #1;
        chk("rst_out_async", {5'd0, hi_out}, 8'h00);
        step();
        chk("rst_pending", hi_pending, 8'h00);
        step();
        chk("rst_valid", {7'd0, hi_valid}, 8'h00);
        chk("rst_out", {5'd0, hi_out}, 8'h00);
        en = 1'b0; in = 8'h00;
        rst_n = 1'b1;

        // Drain order for 8'h24: grant 5 then 2
        en = 1'b1; in = 8'h24;
        step();
        chk("drain_pending_cap", hi_pending, 8'h24);
        chk("drain_valid_lat", {7'd0, hi_valid}, 8'h00);
        en = 1'b0; in = 8'h00;
        step();
        chk("drain_valid1", {7'd0, hi_valid}, 8'h01);
        chk("drain_out5", {5'd0, hi_out}, 8'h05);
        ack = 1'b1;
        step();
        chk("drain_pending_04", hi_pending, 8'h04);
        chk("drain_valid_gap", {7'd0, hi_valid}, 8'h00);
        ack = 1'b0;
        step();
        chk("drain_valid2", {7'd0, hi_valid}, 8'h01);
        chk("drain_out2", {5'd0, hi_out}, 8'h02);
        ack = 1'b1;
        step();
        chk("drain_pending_00", hi_pending, 8'h00);
        ack = 1'b0;
        step();
        chk("drain_idle_valid", {7'd0, hi_valid}, 8'h00);
        chk("drain_out_keep", {5'd0, hi_out}, 8'h02);

        // Enable gating: en=0 ignores requests
        en = 1'b0; in = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("gate_pending", hi_pending, 8'h00);
            chk("gate_valid", {7'd0, hi_valid}, 8'h00);
        end
        en = 1'b1;
        step();
        chk("gate_pending_ff", hi_pending, 8'hFF);
        en = 1'b0; in = 8'h00;
        step();
        chk("gate_out7", {5'd0, hi_out}, 8'h07);
        chk("gate_valid1", {7'd0, hi_valid}, 8'h01);

        // Ack held high: one grant every two cycles, ack ignored in IDLE
        ack = 1'b1;
        step();
        chk("rate_pending_7f", hi_pending, 8'h7F);
        chk("rate_valid_lo", {7'd0, hi_valid}, 8'h00);
        step();
        chk("rate_idle_ack_pend", hi_pending, 8'h7F);
        chk("rate_out6", {5'd0, hi_out}, 8'h06);
        step();
        chk("rate_pending_3f", hi_pending, 8'h3F);
        ack = 1'b0;
        step();
        chk("rate_out5", {5'd0, hi_out}, 8'h05);
        chk("rate_valid5", {7'd0, hi_valid}, 8'h01);

        // Set wins over clear on the granted bit
        ack = 1'b1; en = 1'b1; in = 8'h20;
        step();
        chk("setwin_pending", hi_pending, 8'h3F);
        chk("setwin_valid_lo", {7'd0, hi_valid}, 8'h00);
        ack = 1'b0; en = 1'b0; in = 8'h00;
        step();
        chk("setwin_regrant", {5'd0, hi_out}, 8'h05);
        chk("setwin_valid", {7'd0, hi_valid}, 8'h01);

        // Clean restart
        rst_n = 1'b0; #2; rst_n = 1'b1;

        // No preemption by a higher-priority arrival during HOLD
        en = 1'b1; in = 8'h04;
        step();
        chk("nopre_pending", hi_pending, 8'h04);
        in = 8'h80;
        step();
        chk("nopre_out2", {5'd0, hi_out}, 8'h02);
        chk("nopre_pending_84", hi_pending, 8'h84);
        en = 1'b0; in = 8'h00;
        step();
        chk("nopre_hold_out2", {5'd0, hi_out}, 8'h02);
        chk("nopre_hold_valid", {7'd0, hi_valid}, 8'h01);
        ack = 1'b1;
        step();
        chk("nopre_pending_80", hi_pending, 8'h80);
        ack = 1'b0;
        step();
        chk("nopre_out7", {5'd0, hi_out}, 8'h07);

        // Opposite priority: 8'h24 grants 2 on lo, 5 on hi
        rst_n = 1'b0; #2; rst_n = 1'b1;
        en = 1'b1; in = 8'h24;
        step();
        en = 1'b0; in = 8'h00;
        step();
        chk("lo_out2", {5'd0, lo_out}, 8'h02);
        chk("lo_valid", {7'd0, lo_valid}, 8'h01);
        chk("hi_out5", {5'd0, hi_out}, 8'h05);

        // Reset in the middle of HOLD clears outputs before the next edge
        rst_n = 1'b0; #2; rst_n = 1'b1;
        en = 1'b1; in = 8'h81;
        step();
        en = 1'b0; in = 8'h00;
        step();
        chk("mid_pre_pending", hi_pending, 8'h81);
        chk("mid_pre_valid", {7'd0, hi_valid}, 8'h01);
        chk("mid_pre_out", {5'd0, hi_out}, 8'h07);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", {7'd0, hi_valid}, 8'h00);
        chk("mid_out", {5'd0, hi_out}, 8'h00);
        chk("mid_pending", hi_pending, 8'h00);
        chk("mid_lo_out", {5'd0, lo_out}, 8'h00);
        en = 1'b1; in = 8'hFF;
        step();
        chk("mid_hold_pending", hi_pending, 8'h00);
        en = 1'b0; in = 8'h00;
        rst_n = 1'b1;
        step();
        chk("mid_after_pending", hi_pending, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
